// File: rtl/block_load_writer.sv
// block_load_writer: LDM-style increment-after load sequencer that drives the register-file write port.
// Each listed register gets one memory read. A load to R15 becomes a PC-load strobe.
`default_nettype none

module block_load_writer #(
    parameter logic [31:0] ADDR_INC = 32'd4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [15:0] REGLIST,
    input  logic [31:0] BASE,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_RD,
    input  logic        MEM_RDY,
    input  logic [31:0] MEM_DATA,
    output logic [31:0] PW,
    output logic [3:0]  RW,
    output logic        LE,
    output logic        PC_LD,
    output logic [31:0] PC_VAL,
    output logic        BUSY,
    output logic        DONE
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [15:0] pending;
    logic [15:0] pending_rest;
    logic [31:0] addr;
    logic [3:0]  low_idx;

    always_comb begin
        low_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pending[i]) low_idx = 4'(i);
        end
    end

    assign pending_rest = pending & (pending - 16'd1);
    assign MEM_ADDR     = addr;

    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (START) state_nxt = (REGLIST == 16'd0) ? S_FIN : S_REQ;
            S_REQ:   if (MEM_RDY) state_nxt = S_WRITE;
            S_WRITE: state_nxt = (pending_rest == 16'd0) ? S_FIN : S_REQ;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        MEM_RD = (state == S_REQ);
        LE     = (state == S_WRITE) && (low_idx != 4'd15);
        PC_LD  = (state == S_WRITE) && (low_idx == 4'd15);
        BUSY   = (state != S_IDLE);
        DONE   = (state == S_FIN);
    end

    // Write-port data is captured at the end of REQ so it is already valid
    // during WRITE, and simply holds afterwards.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pending <= 16'd0;
            addr    <= 32'd0;
            PW      <= 32'd0;
            RW      <= 4'd0;
            PC_VAL  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        pending <= REGLIST;
                        addr    <= BASE;
                    end
                end
                S_REQ: begin
                    if (MEM_RDY) begin
                        if (low_idx == 4'd15) begin
                            PC_VAL <= MEM_DATA;
                        end else begin
                            PW <= MEM_DATA;
                            RW <= low_idx;
                        end
                    end
                end
                S_WRITE: begin
                    pending <= pending_rest;
                    addr    <= addr + ADDR_INC;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_block_load_writer.sv
// tb_block_load_writer: randomized bench for block_load_writer against a list-based LDM reference model.
`default_nettype none

module tb_block_load_writer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [15:0] REGLIST;
    logic [31:0] BASE;
    logic [31:0] MEM_ADDR;
    logic        MEM_RD;
    logic        MEM_RDY;
    logic [31:0] MEM_DATA;
    logic [31:0] PW;
    logic [3:0]  RW;
    logic        LE;
    logic        PC_LD;
    logic [31:0] PC_VAL;
    logic        BUSY;
    logic        DONE;

    int checks = 0;
    int errors = 0;
    int nwrites = 0;
    int ndone = 0;

    typedef struct {
        logic        is_pc;
        logic [3:0]  idx;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    block_load_writer #(.ADDR_INC(32'd4)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .REGLIST(REGLIST), .BASE(BASE),
        .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD), .MEM_RDY(MEM_RDY), .MEM_DATA(MEM_DATA),
        .PW(PW), .RW(RW), .LE(LE), .PC_LD(PC_LD), .PC_VAL(PC_VAL),
        .BUSY(BUSY), .DONE(DONE)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hAAAA_0001;
        if (a == 32'h0000_0104) return 32'hBBBB_0002;
        return {a[15:0], ~a[31:16]} ^ 32'h3C96_A51E;
    endfunction

    assign MEM_DATA = MEM_RDY ? mem_fn(MEM_ADDR) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: increment-after, ascending index, one word per listed register.
    task automatic build_model(input logic [15:0] rl, input logic [31:0] b);
        logic [31:0] a;
        exp_t e;
        a = b;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            if (rl[i]) begin
                e.is_pc = (i == 15);
                e.idx   = 4'(i);
                e.addr  = a;
                e.data  = mem_fn(a);
                exp_q.push_back(e);
                a = a + 32'd4;
            end
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET) begin
            if (MEM_RD) begin
                check("rd_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("mem_addr", MEM_ADDR, exp_q[0].addr);
            end
            if (LE || PC_LD) begin
                check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("pc_ld", 32'(PC_LD), 32'(exp_q[0].is_pc));
                    check("le", 32'(LE), 32'(!exp_q[0].is_pc));
                    if (exp_q[0].is_pc) begin
                        check("pc_val", PC_VAL, exp_q[0].data);
                    end else begin
                        check("rw", 32'(RW), 32'(exp_q[0].idx));
                        check("pw", PW, exp_q[0].data);
                    end
                    void'(exp_q.pop_front());
                end
                nwrites++;
            end
            if (DONE) begin
                check("done_all_written", 32'(exp_q.size()), 32'd0);
                ndone++;
            end
        end
    end

    task automatic do_txn(input logic [15:0] rl, input logic [31:0] b, input int rdy_pct,
                          input int stall, input bit poke);
        int cyc;
        int waits;
        int n;
        int stall_left;
        bit seen;
        @(posedge CLK); #1;
        check("idle_busy", 32'(BUSY), 32'd0);
        build_model(rl, b);
        n = exp_q.size();
        START = 1'b1; REGLIST = rl; BASE = b;
        @(posedge CLK); #1;
        START = 1'b0; REGLIST = 16'($urandom); BASE = $urandom;
        cyc = 1; waits = 0; seen = 0; stall_left = stall;
        for (int t = 0; t < 400; t++) begin
            if (DONE) begin
                check("done_cycle", 32'(cyc), 32'(2 * n + 1 + waits));
                seen = 1;
                break;
            end
            check("busy", 32'(BUSY), 32'd1);
            if (MEM_RD && stall_left > 0) begin
                MEM_RDY = 1'b0;
                stall_left--;
            end else begin
                MEM_RDY = ($urandom_range(99) < rdy_pct);
            end
            if (MEM_RD && !MEM_RDY) waits++;
            START = (poke && cyc == 2);
            if (START) REGLIST = 16'($urandom) | 16'h1;
            @(posedge CLK); #1;
            cyc++;
        end
        START = 1'b0;
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int w0;
        int d0;
        logic [15:0] rl;
        RESET = 1'b1; START = 1'b0; REGLIST = 16'd0; BASE = 32'd0; MEM_RDY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_mem_addr", MEM_ADDR, 32'd0);
        check("rst_mem_rd", 32'(MEM_RD), 32'd0);
        check("rst_pw", PW, 32'd0);
        check("rst_rw", 32'(RW), 32'd0);
        check("rst_le", 32'(LE), 32'd0);
        check("rst_pc_ld", 32'(PC_LD), 32'd0);
        check("rst_pc_val", PC_VAL, 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        RESET = 1'b0;

        do_txn(16'h0006, 32'h0000_0100, 100, 0, 0);
        do_txn(16'h8001, 32'h0000_0200, 100, 0, 0);
        w0 = nwrites;
        do_txn(16'h0000, 32'h0000_0300, 100, 0, 0);
        check("empty_no_writes", 32'(nwrites - w0), 32'd0);
        do_txn(16'h0010, 32'h0000_0400, 100, 3, 0);
        do_txn(16'h0003, 32'hFFFF_FFFC, 100, 0, 0);
        do_txn(16'h00F0, 32'h0000_0500, 100, 0, 1);

        // Reset during the second REQ of a four-register load.
        @(posedge CLK); #1;
        build_model(16'h000F, 32'h0000_0600);
        w0 = nwrites; d0 = ndone;
        START = 1'b1; REGLIST = 16'h000F; BASE = 32'h0000_0600; MEM_RDY = 1'b1;
        @(posedge CLK); #1; START = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("rst_mid_in_req", 32'(MEM_RD), 32'd1);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        exp_q.delete();
        check("rst_mid_busy", 32'(BUSY), 32'd0);
        check("rst_mid_le", 32'(LE), 32'd0);
        repeat (4) @(posedge CLK);
        #1;
        check("rst_mid_writes", 32'(nwrites - w0), 32'd1);
        check("rst_mid_no_done", 32'(ndone - d0), 32'd0);

        // Reset beats a simultaneous START.
        RESET = 1'b1; START = 1'b1; REGLIST = 16'h0001;
        @(posedge CLK); #1;
        RESET = 1'b0; START = 1'b0;
        @(posedge CLK); #1;
        check("rst_prio_busy", 32'(BUSY), 32'd0);
        check("rst_prio_rd", 32'(MEM_RD), 32'd0);

        do_txn(16'h0021, 32'h0000_0700, 100, 0, 0);

        for (int k = 0; k < 24; k++) begin
            rl = 16'($urandom) & 16'($urandom);
            if (k % 4 == 0) rl[15] = 1'b1;
            if (k % 7 == 3) rl = 16'h0000;
            do_txn(rl, $urandom & 32'hFFFF_FFFC, 60, 0, (rl != 16'h0000) && (k % 2 == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
